// File: rtl/vga_pkg.sv
// Shared constants, arbiter state type and helpers for the VGA write path.
// Requester lanes: REQ_CLEAR (screen clear), REQ_NOTE (note glyphs),
// REQ_CURSOR (playback cursor).
package vga_pkg;

    localparam int unsigned SCREEN_W   = 160;
    localparam int unsigned SCREEN_H   = 120;
    localparam int unsigned COLOUR_W   = 3;

    localparam int unsigned REQ_CLEAR  = 0;
    localparam int unsigned REQ_NOTE   = 1;
    localparam int unsigned REQ_CURSOR = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN  = 2'd1,
        GAP  = 2'd2
    } arb_state_t;

    // Convert a one-hot grant vector to a lane index (non one-hot maps to 0).
    function automatic logic [1:0] onehot_to_idx(input logic [2:0] oh);
        logic [1:0] idx;
        case (oh)
            3'b001:  idx = 2'd0;
            3'b010:  idx = 2'd1;
            3'b100:  idx = 2'd2;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/vga_write_arbiter_if.sv
// Request/pixel bus between the three drawing engines and the write arbiter.
// Lane i of the packed fields belongs to requester i.
interface vga_write_arbiter_if;

    logic [2:0]  req;
    logic [2:0]  done;
    logic [23:0] in_x;
    logic [20:0] in_y;
    logic [8:0]  in_colour;
    logic [2:0]  in_we;
    logic [2:0]  grant;
    logic [7:0]  x_out;
    logic [6:0]  y_out;
    logic [2:0]  colour;
    logic        writeEn;
    logic        timeout;

    modport master (
        output req, done, in_x, in_y, in_colour, in_we,
        input  grant, x_out, y_out, colour, writeEn, timeout
    );

    modport slave (
        input  req, done, in_x, in_y, in_colour, in_we,
        output grant, x_out, y_out, colour, writeEn, timeout
    );

endinterface

// File: rtl/vga_arb_pick.sv
// Rotating-priority picker: the search starts at lane 'pointer' and wraps
// 2 -> 0. With pointer tied to 0 it degenerates to fixed priority 0 > 1 > 2.
module vga_arb_pick (
    input  logic [2:0] req,
    input  logic [1:0] pointer,
    output logic [2:0] grant
);

    // Select the first requesting lane at or after the pointer.
    always_comb begin
        grant = 3'b000;
        case (pointer)
            2'd1: begin
                if (req[1])      grant = 3'b010;
                else if (req[2]) grant = 3'b100;
                else if (req[0]) grant = 3'b001;
                else             grant = 3'b000;
            end
            2'd2: begin
                if (req[2])      grant = 3'b100;
                else if (req[0]) grant = 3'b001;
                else if (req[1]) grant = 3'b010;
                else             grant = 3'b000;
            end
            default: begin
                if (req[0])      grant = 3'b001;
                else if (req[1]) grant = 3'b010;
                else if (req[2]) grant = 3'b100;
                else             grant = 3'b000;
            end
        endcase
    end

endmodule

// File: rtl/vga_write_arbiter.sv
// Three-way arbiter in front of the VGA adapter pixel port.
// IDLE picks a requester, OWN forwards its pixels (with off-screen clipping)
// until release or hold timeout, GAP inserts one dead cycle before IDLE.
// Optional build macro: VGA_ARB_ROUND_ROBIN_EN selects round-robin picking
// (pointer register); otherwise fixed priority 0 > 1 > 2.
module vga_write_arbiter
    import vga_pkg::*;
#(
    parameter int unsigned HOLD_MAX = 19200
) (
    input  logic               clk,
    input  logic               reset,
    vga_write_arbiter_if.slave bus
);

    localparam logic [14:0] HOLD_LAST = 15'(HOLD_MAX - 1);

    arb_state_t  state_r, state_s;
    logic [2:0]  grant_r, grant_s, pick_s;
    logic [1:0]  gidx_r, gidx_s, ptr_s;
    logic [14:0] hold_cnt_r, hold_cnt_s;
    logic        timeout_r, timeout_s;
    logic [7:0]  x_r;
    logic [6:0]  y_r;
    logic [2:0]  colour_r;
    logic        we_r;
    logic [7:0]  lane_x_s;
    logic [6:0]  lane_y_s;
    logic [2:0]  lane_colour_s;
    logic        lane_we_s, lane_done_s, lane_req_s;
    logic        release_s, clip_s;

`ifdef VGA_ARB_ROUND_ROBIN_EN
    logic [1:0] ptr_r, ptr_nxt_s;

    assign ptr_s = ptr_r;

    // Advance the search start to the lane after each new grant.
    always_comb begin
        ptr_nxt_s = ptr_r;
        if (state_r == IDLE && pick_s != 3'b000) begin
            case (onehot_to_idx(pick_s))
                2'd0:    ptr_nxt_s = 2'd1;
                2'd1:    ptr_nxt_s = 2'd2;
                default: ptr_nxt_s = 2'd0;
            endcase
        end else begin
            ptr_nxt_s = ptr_r;
        end
    end

    // Round-robin pointer register.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_r <= 2'd0;
        end else begin
            ptr_r <= ptr_nxt_s;
        end
    end
`else
    assign ptr_s = 2'd0;
`endif

    vga_arb_pick u_pick (
        .req     (bus.req),
        .pointer (ptr_s),
        .grant   (pick_s)
    );

    // Route the granted lane's pixel and handshake bits.
    always_comb begin
        lane_x_s      = 8'd0;
        lane_y_s      = 7'd0;
        lane_colour_s = 3'd0;
        lane_we_s     = 1'b0;
        lane_done_s   = 1'b0;
        lane_req_s    = 1'b0;
        case (gidx_r)
            2'd0: begin
                lane_x_s      = bus.in_x[7:0];
                lane_y_s      = bus.in_y[6:0];
                lane_colour_s = bus.in_colour[2:0];
                lane_we_s     = bus.in_we[0];
                lane_done_s   = bus.done[0];
                lane_req_s    = bus.req[0];
            end
            2'd1: begin
                lane_x_s      = bus.in_x[15:8];
                lane_y_s      = bus.in_y[13:7];
                lane_colour_s = bus.in_colour[5:3];
                lane_we_s     = bus.in_we[1];
                lane_done_s   = bus.done[1];
                lane_req_s    = bus.req[1];
            end
            2'd2: begin
                lane_x_s      = bus.in_x[23:16];
                lane_y_s      = bus.in_y[20:14];
                lane_colour_s = bus.in_colour[8:6];
                lane_we_s     = bus.in_we[2];
                lane_done_s   = bus.done[2];
                lane_req_s    = bus.req[2];
            end
            default: begin
                lane_x_s      = 8'd0;
                lane_y_s      = 7'd0;
                lane_colour_s = 3'd0;
                lane_we_s     = 1'b0;
                lane_done_s   = 1'b0;
                lane_req_s    = 1'b0;
            end
        endcase
    end

    assign clip_s    = (lane_x_s > 8'(SCREEN_W - 1)) || (lane_y_s > 7'(SCREEN_H - 1));
    assign release_s = lane_done_s | ~lane_req_s;

    // Next state, grant, hold counter and timeout; release beats timeout.
    always_comb begin
        state_s    = state_r;
        grant_s    = grant_r;
        gidx_s     = gidx_r;
        hold_cnt_s = hold_cnt_r;
        timeout_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (pick_s != 3'b000) begin
                    state_s    = OWN;
                    grant_s    = pick_s;
                    gidx_s     = onehot_to_idx(pick_s);
                    hold_cnt_s = 15'd0;
                end else begin
                    state_s    = IDLE;
                end
            end
            OWN: begin
                hold_cnt_s = hold_cnt_r + 15'd1;
                if (release_s) begin
                    state_s = GAP;
                    grant_s = 3'b000;
                end else if (hold_cnt_r == HOLD_LAST) begin
                    state_s   = GAP;
                    grant_s   = 3'b000;
                    timeout_s = 1'b1;
                end else begin
                    state_s = OWN;
                end
            end
            GAP: begin
                state_s = IDLE;
                grant_s = 3'b000;
            end
            default: begin
                state_s = IDLE;
                grant_s = 3'b000;
            end
        endcase
    end

    // Arbiter control registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= IDLE;
            grant_r    <= 3'b000;
            gidx_r     <= 2'd0;
            hold_cnt_r <= 15'd0;
            timeout_r  <= 1'b0;
        end else begin
            state_r    <= state_s;
            grant_r    <= grant_s;
            gidx_r     <= gidx_s;
            hold_cnt_r <= hold_cnt_s;
            timeout_r  <= timeout_s;
        end
    end

    // Pixel output registers: capture while owned, hold coordinates otherwise.
    always_ff @(posedge clk) begin
        if (reset) begin
            x_r      <= 8'd0;
            y_r      <= 7'd0;
            colour_r <= 3'd0;
            we_r     <= 1'b0;
        end else if (state_r == OWN) begin
            x_r      <= lane_x_s;
            y_r      <= lane_y_s;
            colour_r <= lane_colour_s;
            we_r     <= lane_we_s & ~clip_s;
        end else begin
            we_r     <= 1'b0;
        end
    end

    assign bus.grant   = grant_r;
    assign bus.x_out   = x_r;
    assign bus.y_out   = y_r;
    assign bus.colour  = colour_r;
    assign bus.writeEn = we_r;
    assign bus.timeout = timeout_r;

endmodule

// File: tb/tb_vga_write_arbiter.sv
// Self-checking bench for vga_write_arbiter: cycle model of the ownership
// rules checked every cycle, plus literal expectations per scenario.
// Honours VGA_ARB_ROUND_ROBIN_EN for the expected picking order.
module tb_vga_write_arbiter;

    localparam int HOLD_MAX = 8;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    vga_write_arbiter_if bus ();

    vga_write_arbiter #(.HOLD_MAX(HOLD_MAX)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int owner, in_gap, held, rr_next, start_idx, pick_idx;
    logic [2:0] e_grant, e_col;
    logic [7:0] e_x;
    logic [6:0] e_y;
    logic       e_we, e_to;
    bit         model_ok = 1'b0;

    // Predict outputs after each edge from the ownership rules.
    always @(posedge clk) begin
        if (reset) begin
            owner = -1; in_gap = 0; held = 0; rr_next = 0;
            e_grant = 3'b000; e_x = 8'd0; e_y = 7'd0; e_col = 3'd0;
            e_we = 1'b0; e_to = 1'b0;
            model_ok = 1'b1;
        end else begin
            e_we = 1'b0;
            e_to = 1'b0;
            if (owner >= 0) begin
                e_x   = bus.in_x[owner*8 +: 8];
                e_y   = bus.in_y[owner*7 +: 7];
                e_col = bus.in_colour[owner*3 +: 3];
                e_we  = bus.in_we[owner] && (e_x < 160) && (e_y < 120);
                if (bus.done[owner] || !bus.req[owner]) begin
                    owner = -1; in_gap = 1;
                end else if (held + 1 >= HOLD_MAX) begin
                    owner = -1; in_gap = 1; e_to = 1'b1;
                end else begin
                    held++;
                end
            end else if (in_gap != 0) begin
                in_gap = 0;
            end else if (bus.req != 3'b000) begin
`ifdef VGA_ARB_ROUND_ROBIN_EN
                start_idx = rr_next;
`else
                start_idx = 0;
`endif
                pick_idx = -1;
                for (int k = 0; k < 3; k++)
                    if (pick_idx < 0 && bus.req[(start_idx + k) % 3]) pick_idx = (start_idx + k) % 3;
                owner   = pick_idx;
                rr_next = (owner + 1) % 3;
                held    = 0;
            end
            e_grant = (owner >= 0) ? 3'(1 << owner) : 3'b000;
        end
    end

    // Compare every output against the model on the falling edge.
    always @(negedge clk) begin
        if (model_ok) begin
            check("m_grant",   32'(bus.grant),   32'(e_grant));
            check("m_x_out",   32'(bus.x_out),   32'(e_x));
            check("m_y_out",   32'(bus.y_out),   32'(e_y));
            check("m_colour",  32'(bus.colour),  32'(e_col));
            check("m_writeEn", 32'(bus.writeEn), 32'(e_we));
            check("m_timeout", 32'(bus.timeout), 32'(e_to));
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_lane(input int i, input logic [7:0] x, input logic [6:0] y,
                            input logic [2:0] c, input logic we);
        bus.in_x[i*8 +: 8]      = x;
        bus.in_y[i*7 +: 7]      = y;
        bus.in_colour[i*3 +: 3] = c;
        bus.in_we[i]            = we;
    endtask

    logic [2:0] exp_seq [3];
    int wait_cnt;

    initial begin
`ifdef VGA_ARB_ROUND_ROBIN_EN
        exp_seq = '{3'b001, 3'b010, 3'b100};
`else
        exp_seq = '{3'b001, 3'b001, 3'b001};
`endif
        reset = 1'b1;
        bus.req = 3'b000; bus.done = 3'b000;
        bus.in_x = 24'd0; bus.in_y = 21'd0; bus.in_colour = 9'd0; bus.in_we = 3'b000;
        step(2);
        check("rst_grant", 32'(bus.grant), 32'd0);
        check("rst_we",    32'(bus.writeEn), 32'd0);
        check("rst_x",     32'(bus.x_out), 32'd0);
        check("rst_to",    32'(bus.timeout), 32'd0);

        // Basic grant and pixel forwarding, then release with done.
        reset = 1'b0;
        set_lane(1, 8'd10, 7'd20, 3'd5, 1'b1);
        bus.req = 3'b010;
        step(1);
        check("s1_grant", 32'(bus.grant), 32'h2);
        step(1);
        check("s1_x",  32'(bus.x_out), 32'd10);
        check("s1_y",  32'(bus.y_out), 32'd20);
        check("s1_c",  32'(bus.colour), 32'd5);
        check("s1_we", 32'(bus.writeEn), 32'd1);
        bus.done = 3'b010;
        step(1);
        check("s1_rel_grant", 32'(bus.grant), 32'd0);
        check("s1_rel_we",    32'(bus.writeEn), 32'd1);
        bus.done = 3'b000; bus.req = 3'b000;
        set_lane(1, 8'd0, 7'd0, 3'd0, 1'b0);
        step(1);
        check("s1_gap_we", 32'(bus.writeEn), 32'd0);
        step(1);

        // Clipping at the screen edges.
        set_lane(2, 8'd160, 7'd5, 3'd7, 1'b1);
        bus.req = 3'b100;
        step(1);
        check("s2_grant", 32'(bus.grant), 32'h4);
        step(1);
        check("s2_clip_we", 32'(bus.writeEn), 32'd0);
        check("s2_clip_x",  32'(bus.x_out), 32'd160);
        set_lane(2, 8'd159, 7'd119, 3'd2, 1'b1);
        step(1);
        check("s2_edge_we", 32'(bus.writeEn), 32'd1);
        check("s2_edge_y",  32'(bus.y_out), 32'd119);
        set_lane(2, 8'd0, 7'd120, 3'd1, 1'b1);
        step(1);
        check("s2_yclip_we", 32'(bus.writeEn), 32'd0);
        bus.req = 3'b000;
        step(1);
        set_lane(2, 8'd0, 7'd0, 3'd0, 1'b0);
        step(2);

        // Hold timeout and two-cycle regrant gap.
        set_lane(0, 8'd1, 7'd1, 3'd1, 1'b0);
        bus.req = 3'b001;
        step(1);
        check("s3_grant", 32'(bus.grant), 32'h1);
        step(7);
        check("s3_hold_grant", 32'(bus.grant), 32'h1);
        check("s3_hold_to",    32'(bus.timeout), 32'd0);
        step(1);
        check("s3_to_grant", 32'(bus.grant), 32'd0);
        check("s3_to_pulse", 32'(bus.timeout), 32'd1);
        step(1);
        check("s3_idle_grant", 32'(bus.grant), 32'd0);
        check("s3_idle_to",    32'(bus.timeout), 32'd0);
        step(1);
        check("s3_regrant", 32'(bus.grant), 32'h1);
        bus.req = 3'b000;
        step(3);

        // Done coinciding with the timeout cycle: done wins.
        bus.req = 3'b001;
        step(1);
        step(7);
        bus.done = 3'b001;
        step(1);
        check("s4_to",    32'(bus.timeout), 32'd0);
        check("s4_grant", 32'(bus.grant), 32'd0);
        bus.done = 3'b000; bus.req = 3'b000;
        step(2);

        // Non-granted done/we ignored; late request waits for IDLE.
        set_lane(0, 8'd50, 7'd60, 3'd3, 1'b0);
        set_lane(1, 8'd70, 7'd80, 3'd4, 1'b1);
        bus.req = 3'b001;
        step(1);
        bus.done = 3'b010;
        bus.req  = 3'b101;
        step(1);
        check("s5_grant", 32'(bus.grant), 32'h1);
        check("s5_we",    32'(bus.writeEn), 32'd0);
        bus.done = 3'b000;
        bus.req  = 3'b100;
        step(4);
        bus.req = 3'b000;
        set_lane(1, 8'd0, 7'd0, 3'd0, 1'b0);
        step(3);

        // Grant order with all three requesting from pointer 0.
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        bus.req = 3'b111;
        for (int k = 0; k < 3; k++) begin
            wait_cnt = 0;
            while (bus.grant == 3'b000 && wait_cnt < 6) begin
                step(1);
                wait_cnt++;
            end
            check($sformatf("s6_seq%0d", k), 32'(bus.grant), 32'(exp_seq[k]));
            bus.done = bus.grant;
            step(1);
            bus.done = 3'b000;
        end
        bus.req = 3'b000;
        step(3);

        // Reset in the middle of an owned write.
        set_lane(1, 8'd3, 7'd4, 3'd6, 1'b1);
        bus.req = 3'b010;
        step(1);
        step(1);
        check("s7_pre_we", 32'(bus.writeEn), 32'd1);
        reset = 1'b1;
        step(1);
        check("s7_grant", 32'(bus.grant), 32'd0);
        check("s7_we",    32'(bus.writeEn), 32'd0);
        check("s7_x",     32'(bus.x_out), 32'd0);
        check("s7_y",     32'(bus.y_out), 32'd0);
        check("s7_c",     32'(bus.colour), 32'd0);
        check("s7_to",    32'(bus.timeout), 32'd0);
        reset = 1'b0;
        bus.req = 3'b000;
        step(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
